herald_mac_seq: RTL and testbench

HERALD_MAC_SEQ -- requirements
Module: herald_mac_seq

---
 rtl/herald_pkg.sv | 21 ++
 rtl/herald_shift_mul.sv | 62 ++++++
 rtl/herald_mac_seq.sv | 188 ++++++++++++++++++
 tb/tb_herald_mac_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/herald_pkg.sv
// rtl/herald_pkg.sv - shared FSM state type and opcode constants for the MAC sequencer
//
// Purpose: single home for the sequencer state encoding and the 2-bit command opcodes.
// Ports: none (package).
package herald_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      COMPUTE,
      ACCUM,
      SEND
   } state_t;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MAC   = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_READ  = 2'b11;

endpackage

// File: rtl/herald_shift_mul.sv
// rtl/herald_shift_mul.sv - unsigned shift-add multiplier, one multiplier bit per cycle
//
// Purpose: forms a*b over exactly OP_W cycles starting with the start pulse.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse; a and b are captured on this edge
//   a, b       : OP_W-bit unsigned operands
//   done       : one-cycle pulse, OP_W cycles after start, product valid from then on
//   product    : 2*OP_W-bit unsigned result
module herald_shift_mul #(
   parameter int OP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              done,
   output logic [2*OP_W-1:0] product
);

   localparam int CW = $clog2(OP_W + 1);

   logic [2*OP_W-1:0] mcand;
   logic [OP_W-1:0]   mplier;
   logic [CW-1:0]     steps;
   logic              running;

   // The start edge already folds in multiplier bit 0, so the remaining
   // OP_W-1 bits finish exactly OP_W edges after start was raised.
   always_ff @(posedge clk) begin
      if (rst) begin
         done    <= 1'b0;
         running <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         steps   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            product <= b[0] ? {{OP_W{1'b0}}, a} : '0;
            mcand   <= {{(OP_W-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            steps   <= CW'(OP_W - 1);
            running <= 1'b1;
         end else if (running) begin
            if (mplier[0]) begin
               product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            steps  <= steps - CW'(1);
            if (steps == CW'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/herald_mac_seq.sv
// rtl/herald_mac_seq.sv - byte-serial multiply/accumulate sequencer
//
// Purpose: accepts MUL/MAC/CLEAR/READ commands over a byte channel, multiplies
// OP_W-bit operands sequentially and accumulates into an ACC_W-bit register that
// is read back LSB first over a byte result channel.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid, in_ready, in_byte, cmd  : command/operand byte channel (cmd sampled on first byte only)
//   out_valid, out_ready, out_byte    : result byte channel
//   busy                              : high whenever the FSM is not IDLE
//   ovf                               : sticky MAC overflow flag, cleared by CLEAR or reset
module herald_mac_seq
   import herald_pkg::*;
#(
   parameter int OP_W     = 16,
   parameter int ACC_W    = 40,
   parameter int SATURATE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic [1:0] cmd,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_byte,
   output logic       busy,
   output logic       ovf
);

   localparam int NB    = OP_W / 8;
   localparam int NA    = ACC_W / 8;
   localparam int MAXC  = (NA > OP_W) ? NA : OP_W;
   localparam int CNT_W = $clog2(MAXC + 1);

   localparam logic [CNT_W-1:0] LAST_OPB  = CNT_W'(NB - 1);
   localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(OP_W - 1);
   localparam logic [CNT_W-1:0] LAST_ACCB = CNT_W'(NA - 1);

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt;        // operand byte index, compute cycle, or send byte index
   logic [1:0]           op_r;
   logic [OP_W-1:0]      a_r, b_r;
   logic [ACC_W-1:0]     acc;
   logic                 mul_start;
   logic                 mul_done;
   logic [2*OP_W-1:0]    product;
   logic [ACC_W-1:0]     prod_ext;
   logic [ACC_W:0]       mac_sum;

   herald_shift_mul #(.OP_W(OP_W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a_r),
      .b       (b_r),
      .done    (mul_done),
      .product (product)
   );

   assign prod_ext = ACC_W'(product);
   assign mac_sum  = {1'b0, acc} + {1'b0, prod_ext};
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_byte  = 8'h00;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               case (cmd)
                  OP_MUL, OP_MAC: state_n = (NB == 1) ? LOAD_B : LOAD_A;
                  OP_READ:        state_n = SEND;
                  default:        state_n = IDLE;
               endcase
            end
         end
         LOAD_A: begin
            in_ready = 1'b1;
            if (in_valid && cnt == LAST_OPB) state_n = LOAD_B;
         end
         LOAD_B: begin
            in_ready = 1'b1;
            if (in_valid && cnt == LAST_OPB) state_n = COMPUTE;
         end
         COMPUTE: begin
            if (cnt == LAST_CYC) state_n = ACCUM;
         end
         ACCUM: begin
            state_n = IDLE;
         end
         SEND: begin
            out_valid = 1'b1;
            out_byte  = 8'(acc >> {cnt, 3'b000});
            if (out_ready && cnt == LAST_ACCB) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Operands shift in from the top so that after NB bytes the first
   // (least significant) byte has reached bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         op_r      <= OP_MUL;
         a_r       <= '0;
         b_r       <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         mul_start <= 1'b0;
      end else begin
         mul_start <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  case (cmd)
                     OP_MUL, OP_MAC: begin
                        op_r <= cmd;
                        a_r  <= OP_W'({in_byte, a_r} >> 8);
                        cnt  <= (NB == 1) ? '0 : CNT_W'(1);
                     end
                     OP_CLEAR: begin
                        acc <= '0;
                        ovf <= 1'b0;
                     end
                     default: cnt <= '0;
                  endcase
               end
            end
            LOAD_A: begin
               if (in_valid) begin
                  a_r <= OP_W'({in_byte, a_r} >> 8);
                  cnt <= (cnt == LAST_OPB) ? '0 : cnt + CNT_W'(1);
               end
            end
            LOAD_B: begin
               if (in_valid) begin
                  b_r <= OP_W'({in_byte, b_r} >> 8);
                  if (cnt == LAST_OPB) begin
                     cnt       <= '0;
                     mul_start <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            COMPUTE: begin
               cnt <= cnt + CNT_W'(1);
            end
            ACCUM: begin
               cnt <= '0;
               if (mul_done) begin
                  if (op_r == OP_MAC) begin
                     if (mac_sum[ACC_W]) begin
                        ovf <= 1'b1;
                        acc <= (SATURATE != 0) ? '1 : mac_sum[ACC_W-1:0];
                     end else begin
                        acc <= mac_sum[ACC_W-1:0];
                     end
                  end else begin
                     acc <= prod_ext;
                  end
               end
            end
            SEND: begin
               if (out_ready) begin
                  cnt <= (cnt == LAST_ACCB) ? '0 : cnt + CNT_W'(1);
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_herald_mac_seq.sv
// tb/tb_herald_mac_seq.sv - self-checking bench for herald_mac_seq (40-bit wrap, 32-bit wrap, 32-bit saturate)
module tb_herald_mac_seq;
   import herald_pkg::*;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, out_ready;
   logic [7:0] in_byte;
   logic [1:0] cmd;
   logic       in_ready_d [3];
   logic       out_valid_d[3];
   logic       busy_d     [3];
   logic       ovf_d      [3];
   logic [7:0] out_byte_d [3];

   herald_mac_seq #(.OP_W(16), .ACC_W(40), .SATURATE(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[0]), .in_byte(in_byte),
      .cmd(cmd), .out_valid(out_valid_d[0]), .out_ready(out_ready), .out_byte(out_byte_d[0]),
      .busy(busy_d[0]), .ovf(ovf_d[0]));

   herald_mac_seq #(.OP_W(16), .ACC_W(32), .SATURATE(0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[1]), .in_byte(in_byte),
      .cmd(cmd), .out_valid(out_valid_d[1]), .out_ready(out_ready), .out_byte(out_byte_d[1]),
      .busy(busy_d[1]), .ovf(ovf_d[1]));

   herald_mac_seq #(.OP_W(16), .ACC_W(32), .SATURATE(1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d[2]), .in_byte(in_byte),
      .cmd(cmd), .out_valid(out_valid_d[2]), .out_ready(out_ready), .out_byte(out_byte_d[2]),
      .busy(busy_d[2]), .ovf(ovf_d[2]));

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int accw(input int i);
      return (i == 0) ? 40 : 32;
   endfunction

   function automatic logic [63:0] wmask(input int i);
      return (i == 0) ? 64'h00FF_FFFF_FFFF : 64'h0000_FFFF_FFFF;
   endfunction

   logic [63:0] accm [3];
   logic [63:0] snap [3];
   logic [31:0] opd  [3];
   logic [31:0] pend [3];
   logic [1:0]  opm  [3];
   logic        ovfm [3];
   int          cd   [3];   // cycles until the pending result lands
   int          nb   [3];   // operand bytes collected so far
   int          rdk  [3];   // result bytes already delivered
   int          rdleft[3];  // result bytes still owed
   bit          rdy_pre;
   logic [63:0] sum_m;

   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            accm[i] = '0; snap[i] = '0; opd[i] = '0; pend[i] = '0; opm[i] = '0;
            ovfm[i] = 1'b0; cd[i] = 0; nb[i] = 0; rdk[i] = 0; rdleft[i] = 0;
         end else begin
            rdy_pre = (cd[i] == 0) && (rdleft[i] == 0);
            if (rdleft[i] > 0 && out_ready) begin
               rdk[i]++;
               rdleft[i]--;
            end
            if (cd[i] > 0) begin
               cd[i]--;
               if (cd[i] == 0) begin
                  if (opm[i] == OP_MAC) begin
                     sum_m = accm[i] + {32'h0, pend[i]};
                     if (sum_m > wmask(i)) begin
                        ovfm[i] = 1'b1;
                        accm[i] = satm(i) ? wmask(i) : (sum_m & wmask(i));
                     end else begin
                        accm[i] = sum_m;
                     end
                  end else begin
                     accm[i] = {32'h0, pend[i]};
                  end
               end
            end
            if (in_valid && rdy_pre) begin
               if (nb[i] == 0) begin
                  case (cmd)
                     OP_MUL, OP_MAC: begin opm[i] = cmd; opd[i] = {24'h0, in_byte}; nb[i] = 1; end
                     OP_CLEAR:       begin accm[i] = '0; ovfm[i] = 1'b0; end
                     default:        begin snap[i] = accm[i]; rdk[i] = 0; rdleft[i] = accw(i) / 8; end
                  endcase
               end else begin
                  opd[i] = opd[i] | ({24'h0, in_byte} << (8 * nb[i]));
                  nb[i]++;
                  if (nb[i] == 4) begin
                     pend[i] = {16'h0, opd[i][15:0]} * {16'h0, opd[i][31:16]};
                     cd[i]   = 17;
                     nb[i]   = 0;
                  end
               end
            end
         end
      end
   end

   function automatic bit satm(input int i);
      return (i == 2);
   endfunction

   // ---------------- per-cycle compare ----------------
   logic [63:0] exp_b;
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d in_ready", i), 64'(in_ready_d[i]), 64'(cd[i] == 0 && rdleft[i] == 0));
            chk($sformatf("dut%0d busy", i), 64'(busy_d[i]), 64'(cd[i] > 0 || rdleft[i] > 0 || nb[i] > 0));
            chk($sformatf("dut%0d out_valid", i), 64'(out_valid_d[i]), 64'(rdleft[i] > 0));
            chk($sformatf("dut%0d ovf", i), 64'(ovf_d[i]), 64'(ovfm[i]));
            exp_b = (rdleft[i] > 0) ? ((snap[i] >> (8 * rdk[i])) & 64'hFF) : 64'h0;
            chk($sformatf("dut%0d out_byte", i), 64'(out_byte_d[i]), exp_b);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit all_ready();
      return in_ready_d[0] && in_ready_d[1] && in_ready_d[2];
   endfunction

   task automatic wait_ready();
      int t = 0;
      while (!all_ready() && t < 300) begin
         tick();
         t++;
      end
      chk("ready within budget", 64'(all_ready()), 64'd1);
   endtask

   task automatic put(input logic [1:0] c, input logic [7:0] d);
      wait_ready();
      in_valid = 1'b1;
      cmd      = c;
      in_byte  = d;
      tick();
      in_valid = 1'b0;
      cmd      = OP_CLEAR;
      in_byte  = 8'hA5;
   endtask

   // Later bytes carry destructive opcodes on cmd, which must be ignored.
   task automatic mac_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      put(op, a[7:0]);
      put(OP_CLEAR, a[15:8]);
      put(OP_READ, b[7:0]);
      put(OP_CLEAR, b[15:8]);
   endtask

   task automatic read_op(input logic [39:0] exp, input int stall_at, input string tag);
      int got = 0;
      int t = 0;
      int stall = 0;
      logic [7:0] eb;
      put(OP_READ, 8'h5A);
      while (got < 5 && t < 100) begin
         eb = 8'(exp >> (8 * got));
         if (got == stall_at && stall < 5) begin
            out_ready = 1'b0;
            stall++;
            chk($sformatf("%s hold byte%0d", tag, got), 64'(out_byte_d[0]), 64'(eb));
         end else begin
            out_ready = 1'b1;
            if (out_valid_d[0]) begin
               chk($sformatf("%s byte%0d", tag, got), 64'(out_byte_d[0]), 64'(eb));
               got++;
            end
         end
         tick();
         t++;
      end
      out_ready = 1'b1;
      chk($sformatf("%s byte count", tag), 64'(got), 64'd5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      rst = 1'b1; in_valid = 1'b0; cmd = OP_MUL; in_byte = 8'h00; out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset in_ready", 64'(in_ready_d[0]), 64'd1);
      chk("reset busy", 64'(busy_d[0]), 64'd0);
      chk("reset ovf", 64'(ovf_d[0]), 64'd0);
      chk("reset out_valid", 64'(out_valid_d[0]), 64'd0);
      chk("reset out_byte", 64'(out_byte_d[0]), 64'd0);

      // MUL basic: 0x1234 * 0x0010
      mac_op(OP_MUL, 16'h1234, 16'h0010);
      bc = 0;
      while (busy_d[0] && bc < 100) begin
         bc++;
         tick();
      end
      chk("MUL busy cycles", 64'(bc), 64'd17);
      chk("model acc after MUL", accm[0], 64'h12340);
      read_op(40'h00_0001_2340, -1, "mul_basic");

      // MAC chain with overflow on the 32-bit instances; in_valid during COMPUTE ignored
      mac_op(OP_MUL, 16'hFFFF, 16'hFFFF);
      mac_op(OP_MAC, 16'hFFFF, 16'hFFFF);
      in_valid = 1'b1;
      cmd      = OP_CLEAR;
      repeat (3) tick();
      in_valid = 1'b0;
      wait_ready();
      chk("mac_chain ovf 40b", 64'(ovf_d[0]), 64'd0);
      chk("mac_chain ovf wrap", 64'(ovf_d[1]), 64'd1);
      chk("mac_chain ovf sat", 64'(ovf_d[2]), 64'd1);
      chk("model acc 40b", accm[0], 64'h1_FFFC_0002);
      chk("model acc wrap", accm[1], 64'hFFFC_0002);
      chk("model acc sat", accm[2], 64'hFFFF_FFFF);
      read_op(40'h01_FFFC_0002, 2, "mac_chain");

      // CLEAR
      put(OP_CLEAR, 8'hFF);
      chk("clear ovf wrap", 64'(ovf_d[1]), 64'd0);
      chk("clear ovf sat", 64'(ovf_d[2]), 64'd0);
      chk("model acc after clear", accm[1], 64'h0);
      read_op(40'h0, -1, "after_clear");

      // MUL then MAC without overflow; READ twice leaves acc intact
      mac_op(OP_MUL, 16'h00FF, 16'h0101);
      mac_op(OP_MAC, 16'h8000, 16'h0002);
      wait_ready();
      chk("model acc mul_mac2", accm[0], 64'h1FFFF);
      read_op(40'h00_0001_FFFF, 0, "mul_mac2");
      read_op(40'h00_0001_FFFF, 4, "reread");

      // Reset four cycles into COMPUTE
      mac_op(OP_MAC, 16'h1234, 16'h5678);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("post-reset busy", 64'(busy_d[0]), 64'd0);
      chk("post-reset in_ready", 64'(in_ready_d[0]), 64'd1);
      read_op(40'h0, -1, "after_rst");
      chk("post-reset ovf", 64'(ovf_d[0]), 64'd0);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
